// File: rtl/apb_usrt_bridge.sv
// APB slave bridging the bus to the USRT byte datapath.
// Register map with wait states, TX/RX FIFOs, sticky RX overflow.
module apb_usrt_bridge #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic              pSelect,
  input  logic              pEnable,
  input  logic              pWrite,
  input  logic [ADDR_W-1:0] pAddress,
  input  logic [DATA_W-1:0] pWData,
  output logic [DATA_W-1:0] pRData,
  output logic              pReady,
  output logic              pSlvErr,
  output logic [DATA_W-1:0] txData,
  output logic              txValid,
  input  logic              txReady,
  input  logic [DATA_W-1:0] rxData,
  input  logic              rxValid,
  output logic              rxReady
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic        complete;

  logic        en_q;
  logic        rx_ovf_q;

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [PW-1:0]     tx_wr_q, tx_rd_q;
  logic [CW-1:0]     tx_cnt_q;
  logic              tx_full, tx_empty;
  logic              tx_push, tx_pop;

  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0]     rx_wr_q, rx_rd_q;
  logic [CW-1:0]     rx_cnt_q;
  logic              rx_full, rx_empty;
  logic              rx_in, rx_push, rx_pop, rx_drop;

  logic              sel_data, sel_stat, sel_ctrl;
  logic              ctrl_wr;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic [4:0]        status;
  logic              unused_addr;

  assign unused_addr = ^pAddress[ADDR_W-1:4];

  assign tx_full  = (tx_cnt_q == DEPTH);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == DEPTH);
  assign rx_empty = (rx_cnt_q == '0);

  assign status = {rx_ovf_q, rx_empty, rx_full,
                   tx_empty, tx_full};

  assign sel_data = (pAddress[3:0] == 4'h0);
  assign sel_stat = (pAddress[3:0] == 4'h4);
  assign sel_ctrl = (pAddress[3:0] == 4'h8);

  assign txValid = en_q & ~tx_empty;
  assign txData  = tx_empty ? '0 : tx_mem[tx_rd_q];
  assign tx_pop  = txValid & txReady;

  assign rxReady = en_q;
  assign rx_in   = rxValid & rxReady;
  assign rx_push = rx_in & (~rx_full | rx_pop);
  assign rx_drop = rx_in & rx_full & ~rx_pop;

  // APB state and wait-state counter register
  always_ff @(posedge pClk) begin
    if (pReset) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Setup/access sequencing; complete marks the pReady cycle
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pSelect && !pEnable) begin
          state_d = ACCESS;
          wait_d  = '0;
        end
      end
      ACCESS: begin
        if (!pSelect) begin
          state_d = IDLE;
        end else if (wait_q < WS) begin
          wait_d = wait_q + 3'd1;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
    endcase
  end

  // Register decode, error detection and read mux
  always_comb begin
    err     = 1'b0;
    rdata   = '0;
    tx_push = 1'b0;
    rx_pop  = 1'b0;
    ctrl_wr = 1'b0;
    if (complete) begin
      unique case (1'b1)
        sel_data: begin
          if (pWrite) begin
            if (tx_full) err = 1'b1;
            else         tx_push = 1'b1;
          end else begin
            if (rx_empty) begin
              err = 1'b1;
            end else begin
              rx_pop = 1'b1;
              rdata  = rx_mem[rx_rd_q];
            end
          end
        end
        sel_stat: begin
          if (pWrite) err = 1'b1;
          else        rdata = DATA_W'(status);
        end
        sel_ctrl: begin
          if (pWrite) ctrl_wr = 1'b1;
          else        rdata = DATA_W'(en_q);
        end
        default: err = 1'b1;
      endcase
    end
  end

  assign pReady  = complete;
  assign pSlvErr = err;
  assign pRData  = rdata;

  // Control bit and sticky overflow; a drop beats a clear
  always_ff @(posedge pClk) begin
    if (pReset) begin
      en_q     <= 1'b1;
      rx_ovf_q <= 1'b0;
    end else begin
      if (ctrl_wr) en_q <= pWData[0];
      if (rx_drop) rx_ovf_q <= 1'b1;
      else if (ctrl_wr && pWData[1]) rx_ovf_q <= 1'b0;
    end
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge pClk) begin
    if (pReset) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    end
  end

  // TX FIFO storage
  always_ff @(posedge pClk) begin
    if (tx_push) tx_mem[tx_wr_q] <= pWData;
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge pClk) begin
    if (pReset) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // RX FIFO storage; full slot is reused when popped same edge
  always_ff @(posedge pClk) begin
    if (rx_push) rx_mem[rx_wr_q] <= rxData;
  end

endmodule

// File: tb/tb_apb_usrt_bridge.sv
// Randomised bench for apb_usrt_bridge against a queue-based
// model of the register map, FIFOs and USRT handshakes.
module tb_apb_usrt_bridge;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int WS    = 2;

  logic          pClk = 1'b0;
  logic          pReset;
  logic          pSelect, pEnable, pWrite;
  logic [AW-1:0] pAddress;
  logic [DW-1:0] pWData, pRData;
  logic          pReady, pSlvErr;
  logic [DW-1:0] txData;
  logic          txValid, txReady;
  logic [DW-1:0] rxData;
  logic          rxValid, rxReady;

  int ntests = 0;
  int nfail  = 0;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit         m_en;
  bit         m_ovf;

  logic [7:0] o_rd, e_rd;
  logic       o_err, e_err;
  int         o_lat;
  bit         o_ok;

  apb_usrt_bridge #(
    .DATA_W(DW), .ADDR_W(AW),
    .FIFO_DEPTH(DEPTH), .WAIT_STATES(WS)
  ) dut (
    .pClk(pClk), .pReset(pReset),
    .pSelect(pSelect), .pEnable(pEnable),
    .pWrite(pWrite), .pAddress(pAddress),
    .pWData(pWData), .pRData(pRData),
    .pReady(pReady), .pSlvErr(pSlvErr),
    .txData(txData), .txValid(txValid),
    .txReady(txReady), .rxData(rxData),
    .rxValid(rxValid), .rxReady(rxReady)
  );

  always #5 pClk = ~pClk;

  function automatic void model_reset();
    txq.delete();
    rxq.delete();
    m_en  = 1'b1;
    m_ovf = 1'b0;
  endfunction

  function automatic logic [7:0] model_status();
    return {3'b000, m_ovf, rxq.size() == 0,
            rxq.size() == DEPTH, txq.size() == 0,
            txq.size() == DEPTH};
  endfunction

  // Effect of one completed APB transfer plus any same-edge RX byte
  function automatic void model_apb(
    input bit wr, input logic [7:0] a, input logic [7:0] wd,
    input bit rxv, input logic [7:0] rxd,
    output logic [7:0] erd, output logic eerr);
    bit pre_en   = m_en;
    bit pre_full = (rxq.size() == DEPTH);
    bit popped   = 1'b0;
    erd  = 8'h00;
    eerr = 1'b0;
    case (a[3:0])
      4'h0: begin
        if (wr) begin
          if (txq.size() == DEPTH) eerr = 1'b1;
          else txq.push_back(wd);
        end else if (rxq.size() == 0) begin
          eerr = 1'b1;
        end else begin
          erd    = rxq.pop_front();
          popped = 1'b1;
        end
      end
      4'h4: begin
        if (wr) eerr = 1'b1;
        else    erd  = model_status();
      end
      4'h8: begin
        if (wr) begin
          m_en = wd[0];
          if (wd[1]) m_ovf = 1'b0;
        end else begin
          erd = {7'b0, m_en};
        end
      end
      default: eerr = 1'b1;
    endcase
    if (rxv && pre_en) begin
      if (!pre_full || popped) rxq.push_back(rxd);
      else m_ovf = 1'b1;
    end
  endfunction

  task automatic apb(
    input bit wr, input logic [7:0] a, input logic [7:0] wd,
    input bit rxv, input logic [7:0] rxd,
    output logic [7:0] rd, output logic err,
    output int lat, output bit ok);
    pSelect  = 1'b1;
    pEnable  = 1'b0;
    pWrite   = wr;
    pAddress = a;
    pWData   = wd;
    @(posedge pClk); #1;
    pEnable = 1'b1;
    lat = 1;
    while (pReady !== 1'b1 && lat < 20) begin
      @(posedge pClk); #1;
      lat++;
    end
    ok  = (pReady === 1'b1);
    rd  = pRData;
    err = pSlvErr;
    if (rxv) begin
      rxValid = 1'b1;
      rxData  = rxd;
    end
    @(posedge pClk); #1;
    pSelect = 1'b0;
    pEnable = 1'b0;
    rxValid = 1'b0;
  endtask

  task automatic xfer(
    input bit wr, input logic [7:0] a, input logic [7:0] wd,
    input bit rxv, input logic [7:0] rxd);
    model_apb(wr, a, wd, rxv, rxd, e_rd, e_err);
    apb(wr, a, wd, rxv, rxd, o_rd, o_err, o_lat, o_ok);
  endtask

  task automatic usrt_cycle(
    input bit txr, input bit rxv, input logic [7:0] rxd);
    bit pre_en = m_en;
    txReady = txr;
    rxValid = rxv;
    rxData  = rxd;
    if (txr && pre_en && txq.size() > 0) void'(txq.pop_front());
    if (rxv && pre_en) begin
      if (rxq.size() < DEPTH) rxq.push_back(rxd);
      else m_ovf = 1'b1;
    end
    @(posedge pClk); #1;
    txReady = 1'b0;
    rxValid = 1'b0;
  endtask

  task automatic do_reset();
    pReset = 1'b1;
    pSelect = 1'b0;
    pEnable = 1'b0;
    @(posedge pClk); #1;
    @(posedge pClk); #1;
    pReset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    ntests++;
    if (pReady !== 1'b0 || pSlvErr !== 1'b0 || pRData !== 8'h00 ||
        txValid !== 1'b0 || txData !== 8'h00 || rxReady !== 1'b1) begin
      nfail++;
      $display("FAIL reset_outputs: rdy=%b err=%b rd=%h txv=%b txd=%h rxr=%b want 0 0 00 0 00 1",
               pReady, pSlvErr, pRData, txValid, txData, rxReady);
    end
    xfer(1'b0, 8'h04, 8'h00, 1'b0, 8'h00);
    ntests++;
    if (!o_ok || o_lat != WS + 1 || o_rd !== 8'h0A || o_err !== 1'b0 || e_rd !== 8'h0A) begin
      nfail++;
      $display("FAIL reset_status: rd=%h err=%b lat=%0d want rd=0a err=0 lat=%0d",
               o_rd, o_err, o_lat, WS + 1);
    end
  endtask

  task automatic test_tx_basic();
    xfer(1'b1, 8'h00, 8'h5A, 1'b0, 8'h00);
    ntests++;
    if (!o_ok || o_lat != WS + 1 || o_err !== 1'b0) begin
      nfail++;
      $display("FAIL tx_write: err=%b lat=%0d want err=0 lat=%0d", o_err, o_lat, WS + 1);
    end
    ntests++;
    if (txValid !== 1'b1 || txData !== 8'h5A) begin
      nfail++;
      $display("FAIL tx_visible: txv=%b txd=%h want 1 5a", txValid, txData);
    end
    usrt_cycle(1'b1, 1'b0, 8'h00);
    xfer(1'b0, 8'h04, 8'h00, 1'b0, 8'h00);
    ntests++;
    if (o_rd !== e_rd || o_rd[1] !== 1'b1 || o_err !== 1'b0) begin
      nfail++;
      $display("FAIL tx_popped_status: rd=%h want %h", o_rd, e_rd);
    end
  endtask

  task automatic test_tx_fill();
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      xfer(1'b1, 8'h00, 8'($urandom), 1'b0, 8'h00);
      if (o_err !== 1'b0 || !o_ok) bad++;
    end
    ntests++;
    if (bad != 0) begin
      nfail++;
      $display("FAIL tx_fill: %0d writes errored, want 0", bad);
    end
    xfer(1'b1, 8'h00, 8'hEE, 1'b0, 8'h00);
    ntests++;
    if (o_err !== 1'b1 || e_err !== 1'b1) begin
      nfail++;
      $display("FAIL tx_overfill: err=%b want 1", o_err);
    end
    xfer(1'b0, 8'h04, 8'h00, 1'b0, 8'h00);
    ntests++;
    if (o_rd !== e_rd || o_rd !== 8'h09) begin
      nfail++;
      $display("FAIL tx_full_status: rd=%h want 09 (model %h)", o_rd, e_rd);
    end
    for (int i = 0; i < DEPTH; i++) begin
      ntests++;
      if (txValid !== 1'b1 || txData !== txq[0]) begin
        nfail++;
        $display("FAIL tx_drain[%0d]: txv=%b txd=%h want 1 %h", i, txValid, txData, txq[0]);
      end
      usrt_cycle(1'b1, 1'b0, 8'h00);
    end
    ntests++;
    if (txValid !== 1'b0) begin
      nfail++;
      $display("FAIL tx_drained: txv=%b want 0", txValid);
    end
  endtask

  task automatic test_rx_overflow();
    for (int i = 0; i < DEPTH + 1; i++)
      usrt_cycle(1'b0, 1'b1, 8'($urandom));
    xfer(1'b0, 8'h04, 8'h00, 1'b0, 8'h00);
    ntests++;
    if (o_rd !== e_rd || o_rd[4] !== 1'b1 || o_rd[2] !== 1'b1) begin
      nfail++;
      $display("FAIL rx_ovf_status: rd=%h want %h", o_rd, e_rd);
    end
    xfer(1'b1, 8'h08, 8'h03, 1'b0, 8'h00);
    xfer(1'b0, 8'h04, 8'h00, 1'b0, 8'h00);
    ntests++;
    if (o_rd !== e_rd || o_rd[4] !== 1'b0) begin
      nfail++;
      $display("FAIL rx_ovf_clear: rd=%h want %h", o_rd, e_rd);
    end
    for (int i = 0; i < DEPTH; i++) begin
      xfer(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
      ntests++;
      if (o_rd !== e_rd || o_err !== 1'b0) begin
        nfail++;
        $display("FAIL rx_read[%0d]: rd=%h err=%b want %h 0", i, o_rd, o_err, e_rd);
      end
    end
    xfer(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    ntests++;
    if (o_err !== 1'b1 || o_rd !== 8'h00 || e_err !== 1'b1) begin
      nfail++;
      $display("FAIL rx_empty_read: rd=%h err=%b want 00 1", o_rd, o_err);
    end
  endtask

  task automatic test_rx_same_edge();
    for (int i = 0; i < DEPTH; i++)
      usrt_cycle(1'b0, 1'b1, 8'($urandom));
    xfer(1'b0, 8'h00, 8'h00, 1'b1, 8'hC3);
    ntests++;
    if (o_rd !== e_rd || o_err !== 1'b0) begin
      nfail++;
      $display("FAIL rx_same_edge_read: rd=%h err=%b want %h 0", o_rd, o_err, e_rd);
    end
    xfer(1'b0, 8'h04, 8'h00, 1'b0, 8'h00);
    ntests++;
    if (o_rd !== e_rd || o_rd[4] !== 1'b0 || o_rd[2] !== 1'b1) begin
      nfail++;
      $display("FAIL rx_same_edge_status: rd=%h want %h", o_rd, e_rd);
    end
    for (int i = 0; i < DEPTH; i++) begin
      xfer(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
      ntests++;
      if (o_rd !== e_rd || o_err !== 1'b0) begin
        nfail++;
        $display("FAIL rx_order[%0d]: rd=%h want %h", i, o_rd, e_rd);
      end
    end
  endtask

  task automatic test_bad_addr();
    xfer(1'b0, 8'h0C, 8'h00, 1'b0, 8'h00);
    ntests++;
    if (o_err !== 1'b1 || o_rd !== 8'h00 || o_lat != WS + 1) begin
      nfail++;
      $display("FAIL bad_addr_read: rd=%h err=%b want 00 1", o_rd, o_err);
    end
    xfer(1'b1, 8'h04, 8'hFF, 1'b0, 8'h00);
    ntests++;
    if (o_err !== 1'b1) begin
      nfail++;
      $display("FAIL status_write: err=%b want 1", o_err);
    end
    xfer(1'b1, 8'h0C, 8'h00, 1'b0, 8'h00);
    xfer(1'b0, 8'h38, 8'h00, 1'b0, 8'h00);
    ntests++;
    if (o_rd !== e_rd || o_err !== 1'b0 || o_rd !== 8'h01) begin
      nfail++;
      $display("FAIL ctrl_alias: rd=%h err=%b want 01 0", o_rd, o_err);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    for (int i = 0; i < 3; i++) begin
      xfer(1'b1, 8'h00, 8'($urandom), 1'b0, 8'h00);
      if (!o_ok || o_lat != WS + 1 || o_err !== 1'b0) bad++;
    end
    ntests++;
    if (bad != 0) begin
      nfail++;
      $display("FAIL back_to_back: %0d transfers wrong, want 0", bad);
    end
    for (int i = 0; i < 3; i++) begin
      ntests++;
      if (txValid !== 1'b1 || txData !== txq[0]) begin
        nfail++;
        $display("FAIL b2b_drain[%0d]: txd=%h want %h", i, txData, txq[0]);
      end
      usrt_cycle(1'b1, 1'b0, 8'h00);
    end
  endtask

  task automatic test_abort();
    int rdy = 0;
    usrt_cycle(1'b0, 1'b1, 8'h77);
    for (int k = 0; k < 2; k++) begin
      pSelect  = 1'b1;
      pEnable  = 1'b0;
      pWrite   = (k == 1);
      pAddress = 8'h00;
      pWData   = 8'h99;
      @(posedge pClk); #1;
      pEnable = 1'b1;
      if (pReady === 1'b1) rdy++;
      @(posedge pClk); #1;
      if (pReady === 1'b1) rdy++;
      pSelect = 1'b0;
      pEnable = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(posedge pClk); #1;
        if (pReady === 1'b1) rdy++;
      end
    end
    ntests++;
    if (rdy != 0) begin
      nfail++;
      $display("FAIL abort_ready: pReady seen %0d times, want 0", rdy);
    end
    ntests++;
    if (txValid !== 1'b0) begin
      nfail++;
      $display("FAIL abort_no_push: txv=%b want 0", txValid);
    end
    xfer(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    ntests++;
    if (o_rd !== 8'h77 || o_err !== 1'b0) begin
      nfail++;
      $display("FAIL abort_no_pop: rd=%h err=%b want 77 0", o_rd, o_err);
    end
  endtask

  task automatic test_reset_mid();
    xfer(1'b1, 8'h00, 8'h42, 1'b0, 8'h00);
    usrt_cycle(1'b0, 1'b1, 8'h24);
    pSelect  = 1'b1;
    pEnable  = 1'b0;
    pWrite   = 1'b0;
    pAddress = 8'h00;
    @(posedge pClk); #1;
    pEnable = 1'b1;
    pReset  = 1'b1;
    @(posedge pClk); #1;
    pReset = 1'b0;
    model_reset();
    ntests++;
    if (pReady !== 1'b0 || pSlvErr !== 1'b0 || pRData !== 8'h00 ||
        txValid !== 1'b0 || txData !== 8'h00 || rxReady !== 1'b1) begin
      nfail++;
      $display("FAIL reset_mid: rdy=%b err=%b rd=%h txv=%b txd=%h rxr=%b want 0 0 00 0 00 1",
               pReady, pSlvErr, pRData, txValid, txData, rxReady);
    end
    @(posedge pClk); #1;
    pSelect = 1'b0;
    pEnable = 1'b0;
    xfer(1'b0, 8'h04, 8'h00, 1'b0, 8'h00);
    ntests++;
    if (o_rd !== 8'h0A || o_rd !== e_rd) begin
      nfail++;
      $display("FAIL reset_mid_status: rd=%h want 0a", o_rd);
    end
  endtask

  task automatic test_enable();
    xfer(1'b1, 8'h00, 8'h3C, 1'b0, 8'h00);
    xfer(1'b1, 8'h08, 8'h00, 1'b0, 8'h00);
    ntests++;
    if (txValid !== 1'b0 || rxReady !== 1'b0) begin
      nfail++;
      $display("FAIL disabled: txv=%b rxr=%b want 0 0", txValid, rxReady);
    end
    usrt_cycle(1'b1, 1'b1, 8'h11);
    xfer(1'b0, 8'h04, 8'h00, 1'b0, 8'h00);
    ntests++;
    if (o_rd !== e_rd || o_err !== 1'b0) begin
      nfail++;
      $display("FAIL disabled_status: rd=%h want %h", o_rd, e_rd);
    end
    xfer(1'b1, 8'h08, 8'h01, 1'b0, 8'h00);
    ntests++;
    if (txValid !== 1'b1 || txData !== 8'h3C || rxReady !== 1'b1) begin
      nfail++;
      $display("FAIL reenabled: txv=%b txd=%h rxr=%b want 1 3c 1", txValid, txData, rxReady);
    end
    usrt_cycle(1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    int bad = 0;
    int op;
    logic [7:0] a;
    for (int n = 0; n < 250; n++) begin
      op = $urandom_range(0, 9);
      if (op >= 6 && op <= 7) begin
        ntests++;
        if (txValid !== (m_en && txq.size() > 0) || rxReady !== m_en ||
            (txq.size() > 0 && txData !== txq[0])) begin
          nfail++;
          bad++;
          $display("FAIL rand_usrt[%0d]: txv=%b txd=%h rxr=%b", n, txValid, txData, rxReady);
        end
        usrt_cycle(1'($urandom), 1'($urandom), 8'($urandom));
      end else begin
        case (op)
          0, 1, 2: xfer(1'b1, 8'h00, 8'($urandom), 1'($urandom_range(0, 3) == 0), 8'($urandom));
          3, 4:    xfer(1'b0, 8'h00, 8'h00, 1'($urandom), 8'($urandom));
          5:       xfer(1'b0, 8'h04, 8'h00, 1'($urandom), 8'($urandom));
          8: begin
            a = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'h01 | 8'({$urandom_range(0, 1), 1'b0});
            xfer(1'b1, 8'h08, a, 1'b0, 8'h00);
          end
          default: begin
            a = 8'($urandom);
            xfer(1'($urandom), a, 8'($urandom) | 8'h01, 1'($urandom), 8'($urandom));
          end
        endcase
        ntests++;
        if (!o_ok || o_lat != WS + 1 || o_rd !== e_rd || o_err !== e_err) begin
          nfail++;
          bad++;
          $display("FAIL rand_apb[%0d]: rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
                   n, o_rd, o_err, o_lat, e_rd, e_err, WS + 1);
        end
      end
      if (bad > 10) break;
    end
  endtask

  initial begin
    pReset   = 1'b1;
    pSelect  = 1'b0;
    pEnable  = 1'b0;
    pWrite   = 1'b0;
    pAddress = '0;
    pWData   = '0;
    txReady  = 1'b0;
    rxValid  = 1'b0;
    rxData   = '0;
    model_reset();
    test_reset();
    test_tx_basic();
    test_tx_fill();
    test_rx_overflow();
    test_rx_same_edge();
    test_bad_addr();
    test_back_to_back();
    test_abort();
    test_enable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
